// File: rtl/ahb_wb_pkg.sv
// Shared AHB / Wishbone bridge definitions: HTRANS/HRESP encodings, HSIZE codes,
// bridge FSM states and the transfer-legality helper used by both bridge directions.
package ahb_wb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;
  localparam logic [1:0] HRESP_RETRY = 2'b10;
  localparam logic [1:0] HRESP_SPLIT = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WB_WAIT = 2'd1,
    ST_ERR1    = 2'd2,
    ST_ERR2    = 2'd3
  } bridge_state_e;

  // Sizes above a word, or addresses not aligned to the size, cannot map to one WB cycle.
  function automatic logic size_legal(input logic [2:0] hsize, input logic [1:0] addr);
    case (hsize)
      HSIZE_BYTE: size_legal = 1'b1;
      HSIZE_HALF: size_legal = ~addr[0];
      HSIZE_WORD: size_legal = (addr == 2'b00);
      default:    size_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ahb_wb_sel_dec.sv
// Little-endian byte-lane decode from AHB transfer size and low address bits.
module ahb_wb_sel_dec
  import ahb_wb_pkg::*;
(
  input  logic [2:0] hsize_i,
  input  logic [1:0] addr_i,
  output logic [3:0] sel_o
);

  always_comb begin
    sel_o = 4'b1111;
    case (hsize_i)
      HSIZE_BYTE: sel_o = 4'b0001 << addr_i;
      HSIZE_HALF: sel_o = addr_i[1] ? 4'b1100 : 4'b0011;
      default:    sel_o = 4'b1111;
    endcase
  end

endmodule

// File: rtl/ahbslv_wbmas_bridge.sv
// AHB-Lite slave to Wishbone classic master bridge: one WB cycle per AHB beat.
// Optional WB wait-cycle timeout abort: define AHBSLV_WBMAS_TIMEOUT_EN.
module ahbslv_wbmas_bridge
  import ahb_wb_pkg::*;
#(
  parameter int AWIDTH  = 32,
  parameter int DWIDTH  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic              hsel,
  input  logic              hwrite,
  input  logic              hreadyin,
  input  logic [AWIDTH-1:0] haddr,
  input  logic [1:0]        htrans,
  input  logic [2:0]        hsize,
  input  logic [2:0]        hburst,
  input  logic [DWIDTH-1:0] hwdata,
  output logic              hreadyout,
  output logic [1:0]        hresp,
  output logic [DWIDTH-1:0] hrdata,
  output logic [AWIDTH-1:0] adr_o,
  output logic [DWIDTH-1:0] dat_o,
  output logic [3:0]        sel_o,
  output logic              we_o,
  output logic              cyc_o,
  output logic              stb_o,
  input  logic [DWIDTH-1:0] dat_i,
  input  logic              ack_i,
  input  logic              err_i,
  output logic [1:0]        dbg_state_o
);

  bridge_state_e     state_q;
  logic              hreadyout_q;
  logic [1:0]        hresp_q;
  logic [DWIDTH-1:0] hrdata_q;
  logic [AWIDTH-1:0] adr_q;
  logic [3:0]        sel_q;
  logic              we_q;
  logic              cyc_q;
  logic              accept;
  logic              legal;
  logic [3:0]        sel_d;
  logic              unused_inputs;

  // Bursts are split into independent beats, so only the NONSEQ/SEQ distinction matters.
  assign unused_inputs = ^{htrans[0], hburst};

  assign accept = hsel && hreadyin && htrans[1] &&
                  ((state_q == ST_IDLE) || (state_q == ST_ERR2));
  assign legal  = size_legal(hsize, haddr[1:0]);

  ahb_wb_sel_dec u_sel_dec (
    .hsize_i (hsize),
    .addr_i  (haddr[1:0]),
    .sel_o   (sel_d)
  );

`ifdef AHBSLV_WBMAS_TIMEOUT_EN
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_q;
`else
  localparam int unused_timeout = TIMEOUT;
`endif

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q     <= ST_IDLE;
      hreadyout_q <= 1'b1;
      hresp_q     <= HRESP_OKAY;
      hrdata_q    <= '0;
      adr_q       <= '0;
      sel_q       <= '0;
      we_q        <= 1'b0;
      cyc_q       <= 1'b0;
`ifdef AHBSLV_WBMAS_TIMEOUT_EN
      tmo_q       <= '0;
`endif
    end else begin
      case (state_q)
        // ERR2 and the OKAY cycle both complete a beat, so the next beat may start there.
        ST_IDLE, ST_ERR2: begin
          if (accept && legal) begin
            state_q     <= ST_WB_WAIT;
            adr_q       <= haddr;
            sel_q       <= sel_d;
            we_q        <= hwrite;
            cyc_q       <= 1'b1;
            hreadyout_q <= 1'b0;
            hresp_q     <= HRESP_OKAY;
`ifdef AHBSLV_WBMAS_TIMEOUT_EN
            tmo_q       <= TW'(TIMEOUT);
`endif
          end else if (accept) begin
            state_q     <= ST_ERR1;
            hreadyout_q <= 1'b0;
            hresp_q     <= HRESP_ERROR;
          end else begin
            state_q     <= ST_IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
          end
        end
        ST_WB_WAIT: begin
          if (err_i) begin
            state_q <= ST_ERR1;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            hresp_q <= HRESP_ERROR;
          end else if (ack_i) begin
            state_q     <= ST_IDLE;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
            if (!we_q) hrdata_q <= dat_i;
          end
`ifdef AHBSLV_WBMAS_TIMEOUT_EN
          else if ((tmo_q == '0) || (tmo_q == TW'(1))) begin
            state_q <= ST_ERR1;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            hresp_q <= HRESP_ERROR;
          end else begin
            tmo_q <= tmo_q - TW'(1);
          end
`endif
        end
        ST_ERR1: begin
          state_q     <= ST_ERR2;
          hreadyout_q <= 1'b1;
          hresp_q     <= HRESP_ERROR;
        end
        default: begin
          state_q     <= ST_IDLE;
          hreadyout_q <= 1'b1;
          hresp_q     <= HRESP_OKAY;
        end
      endcase
    end
  end

  assign hreadyout   = hreadyout_q;
  assign hresp       = hresp_q;
  assign hrdata      = hrdata_q;
  assign adr_o       = adr_q;
  assign sel_o       = sel_q;
  assign we_o        = we_q;
  assign cyc_o       = cyc_q;
  assign stb_o       = cyc_q;
  // The AHB master holds hwdata stable for the whole data phase.
  assign dat_o       = hwdata;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ahbslv_wbmas_bridge.sv
// Table-driven bench for the AHB-slave / WB-master bridge with an expected-result queue
// and hand-written sequences for back-to-back, reset and timeout corners.
module tb_ahbslv_wbmas_bridge;

  localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;
  localparam logic [1:0] R_OKAY = 2'b00, R_ERR = 2'b01;

  logic        hclk = 1'b0;
  logic        hresetn = 1'b0;
  logic        hsel = 1'b0, hwrite = 1'b0, hreadyin = 1'b1;
  logic [31:0] haddr = '0, hwdata = '0, dat_i = '0;
  logic [1:0]  htrans = T_IDLE;
  logic [2:0]  hsize = 3'b010, hburst = 3'b000;
  logic        ack_i = 1'b0, err_i = 1'b0;
  logic        hreadyout, we_o, cyc_o, stb_o;
  logic [1:0]  hresp, dbg_state;
  logic [31:0] hrdata, adr_o, dat_o;
  logic [3:0]  sel_o;

  int checks = 0;
  int failures = 0;

  always #5 hclk = ~hclk;

  ahbslv_wbmas_bridge #(.AWIDTH(32), .DWIDTH(32), .TIMEOUT(4)) dut (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel), .hwrite(hwrite), .hreadyin(hreadyin),
    .haddr(haddr), .htrans(htrans), .hsize(hsize), .hburst(hburst), .hwdata(hwdata),
    .hreadyout(hreadyout), .hresp(hresp), .hrdata(hrdata), .adr_o(adr_o), .dat_o(dat_o),
    .sel_o(sel_o), .we_o(we_o), .cyc_o(cyc_o), .stb_o(stb_o), .dat_i(dat_i),
    .ack_i(ack_i), .err_i(err_i), .dbg_state_o(dbg_state)
  );

  typedef struct {
    string       name;
    logic        hsel;
    logic        hready;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic [31:0] rdata;
    int          wb_wait;
    logic        wb_err;
    logic        exp_cyc;
    logic [3:0]  exp_sel;
    int          exp_waits;
    logic [1:0]  exp_resp;
  } vec_t;

  typedef struct packed {
    logic        cyc;
    logic [3:0]  sel;
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [7:0]  waits;
    logic [1:0]  resp;
    logic        chk_rd;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] model_sel(input logic [2:0] sz, input logic [1:0] a);
    logic [3:0] lanes [4];
    lanes[0] = 4'b0001; lanes[1] = 4'b0010; lanes[2] = 4'b0100; lanes[3] = 4'b1000;
    if (sz == 3'b000) return lanes[a];
    if (sz == 3'b001) return (a >= 2'd2) ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  // Entered and left at #1 after a rising edge with the bridge ready for a new beat.
  task automatic run_vec(input vec_t v);
    exp_t        e;
    logic        o_cyc, o_we, done;
    logic [3:0]  o_sel;
    logic [31:0] o_adr, o_dat, o_rd;
    logic [1:0]  o_resp, o_wresp;
    int          cnt, waits;
    e.cyc = v.exp_cyc; e.sel = v.exp_sel; e.we = v.hwrite; e.adr = v.haddr; e.dat = v.hwdata;
    e.waits = 8'(v.exp_waits); e.resp = v.exp_resp;
    e.chk_rd = v.exp_cyc && !v.hwrite && !v.wb_err; e.rdata = v.rdata;
    exp_q.push_back(e);
    hsel = v.hsel; hreadyin = v.hready; htrans = v.htrans; hwrite = v.hwrite;
    hsize = v.hsize; haddr = v.haddr; hburst = 3'($urandom_range(0, 7));
    @(posedge hclk); #1;
    hsel = 1'b0; htrans = T_IDLE; hreadyin = 1'b1; hwdata = v.hwdata;
    cnt = 0; waits = 0; done = 1'b0; o_cyc = 1'b0; o_we = 1'b0; o_sel = '0;
    o_adr = '0; o_dat = '0; o_rd = '0; o_resp = '0; o_wresp = '0;
    for (int c = 0; c < 64 && !done; c++) begin
      ack_i = 1'b0; err_i = 1'b0;
      if (cyc_o) begin
        if (!o_cyc) begin
          o_cyc = 1'b1; o_sel = sel_o; o_we = we_o; o_adr = adr_o; o_dat = dat_o;
        end
        if (cnt == v.wb_wait) begin
          ack_i = ~v.wb_err; err_i = v.wb_err; dat_i = v.rdata;
        end
        cnt++;
      end
      @(negedge hclk);
      if (hreadyout) begin
        done = 1'b1; o_resp = hresp; o_rd = hrdata;
      end else begin
        waits++; o_wresp = hresp;
      end
      @(posedge hclk); #1;
    end
    ack_i = 1'b0; err_i = 1'b0;
    if (!done) chk({v.name, "_timeout"}, 32'(done), 32'd1);
    if (exp_q.size() == 0) begin
      chk({v.name, "_queue"}, 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk({v.name, "_cyc"}, 32'(o_cyc), 32'(e.cyc));
      if (e.cyc) begin
        chk({v.name, "_adr"}, o_adr, e.adr);
        chk({v.name, "_sel"}, 32'(o_sel), 32'(e.sel));
        chk({v.name, "_we"}, 32'(o_we), 32'(e.we));
        if (e.we) chk({v.name, "_dat"}, o_dat, e.dat);
      end
      chk({v.name, "_waits"}, 32'(waits), 32'(e.waits));
      chk({v.name, "_resp"}, 32'(o_resp), 32'(e.resp));
      if (e.resp == R_ERR) chk({v.name, "_err1_resp"}, 32'(o_wresp), 32'(R_ERR));
      if (e.chk_rd) chk({v.name, "_hrdata"}, o_rd, e.rdata);
    end
  endtask

  initial begin
    vec_t rv;
    int   n;
    //           name           sel rdy htrans wr size  haddr          hwdata         rdata          wt err  cyc sel     wts resp
    vecs[0]  = '{"w_word_1004", 1, 1, T_NSEQ, 1, 3'd2, 32'h0000_1004, 32'hDEADBEEF, 32'h0,         0, 0, 1, 4'b1111, 1, R_OKAY};
    vecs[1]  = '{"r_byte_2003", 1, 1, T_NSEQ, 0, 3'd0, 32'h0000_2003, 32'h0,        32'h12345678,  3, 0, 1, 4'b1000, 4, R_OKAY};
    vecs[2]  = '{"r_word_err",  1, 1, T_NSEQ, 0, 3'd2, 32'h0000_0010, 32'h0,        32'h0,         0, 1, 1, 4'b1111, 2, R_ERR};
    vecs[3]  = '{"w_half_unal", 1, 1, T_NSEQ, 1, 3'd1, 32'h0000_0001, 32'h1111,     32'h0,         0, 0, 0, 4'b0000, 1, R_ERR};
    vecs[4]  = '{"r_half_hi",   1, 1, T_NSEQ, 0, 3'd1, 32'h0000_0002, 32'h0,        32'hAABBCCDD,  1, 0, 1, 4'b1100, 2, R_OKAY};
    vecs[5]  = '{"w_byte_5",    1, 1, T_NSEQ, 1, 3'd0, 32'h0000_0005, 32'h0000_00A5, 32'h0,        2, 0, 1, 4'b0010, 3, R_OKAY};
    vecs[6]  = '{"size_011",    1, 1, T_NSEQ, 0, 3'd3, 32'h0000_0000, 32'h0,        32'h0,         0, 0, 0, 4'b0000, 1, R_ERR};
    vecs[7]  = '{"w_word_unal", 1, 1, T_NSEQ, 1, 3'd2, 32'h0000_0002, 32'h0,        32'h0,         0, 0, 0, 4'b0000, 1, R_ERR};
    vecs[8]  = '{"busy",        1, 1, T_BUSY, 0, 3'd2, 32'h0000_0040, 32'h0,        32'h0,         0, 0, 0, 4'b0000, 0, R_OKAY};
    vecs[9]  = '{"idle_tr",     1, 1, T_IDLE, 1, 3'd2, 32'h0000_0044, 32'h0,        32'h0,         0, 0, 0, 4'b0000, 0, R_OKAY};
    vecs[10] = '{"hsel0",       0, 1, T_NSEQ, 0, 3'd2, 32'h0000_0048, 32'h0,        32'h0,         0, 0, 0, 4'b0000, 0, R_OKAY};
    vecs[11] = '{"hready0",     1, 0, T_NSEQ, 0, 3'd2, 32'h0000_004C, 32'h0,        32'h0,         0, 0, 0, 4'b0000, 0, R_OKAY};
    vecs[12] = '{"r_seq_word",  1, 1, T_SEQ,  0, 3'd2, 32'h0000_0020, 32'h0,        32'h0BADF00D,  0, 0, 1, 4'b1111, 1, R_OKAY};
    vecs[13] = '{"r_half_err2", 1, 1, T_NSEQ, 0, 3'd1, 32'h0000_0000, 32'h0,        32'h0,         2, 1, 1, 4'b0011, 4, R_ERR};
    vecs[14] = '{"w_half_lo",   1, 1, T_NSEQ, 1, 3'd1, 32'h0000_0040, 32'h0000_1234, 32'h0,        0, 0, 1, 4'b0011, 1, R_OKAY};

    // Reset values while hresetn is low.
    repeat (3) @(posedge hclk);
    @(negedge hclk);
    chk("rst_hreadyout", 32'(hreadyout), 32'd1);
    chk("rst_hresp", 32'(hresp), 32'd0);
    chk("rst_hrdata", hrdata, 32'd0);
    chk("rst_adr", adr_o, 32'd0);
    chk("rst_sel", 32'(sel_o), 32'd0);
    chk("rst_ctl", 32'({we_o, cyc_o, stb_o}), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);

    // Release and present the first beat in the same cycle: it must be taken at the next edge.
    @(posedge hclk); #1;
    hresetn = 1'b1;
    for (int i = 0; i < 15; i++) begin
      run_vec(vecs[i]);
      if (vecs[i].exp_resp == R_ERR) begin
        @(negedge hclk);
        chk({vecs[i].name, "_after_err"}, 32'({hreadyout, hresp, cyc_o}), 32'({1'b1, R_OKAY, 1'b0}));
        @(posedge hclk); #1;
      end
    end

    // Random legal beats with random WB wait cycles.
    for (int i = 0; i < 6; i++) begin
      rv.name = $sformatf("rand%0d", i);
      rv.hsel = 1'b1; rv.hready = 1'b1; rv.htrans = T_NSEQ;
      rv.hwrite = 1'($urandom_range(0, 1));
      rv.hsize = 3'($urandom_range(0, 2));
      rv.haddr = $urandom & ~((32'd1 << rv.hsize) - 32'd1);
      rv.hwdata = $urandom; rv.rdata = $urandom;
      rv.wb_wait = $urandom_range(0, 3); rv.wb_err = 1'b0;
      rv.exp_cyc = 1'b1; rv.exp_sel = model_sel(rv.hsize, rv.haddr[1:0]);
      rv.exp_waits = rv.wb_wait + 1; rv.exp_resp = R_OKAY;
      run_vec(rv);
    end

    // Unanswered WB cycle: aborts with the timeout build, otherwise waits indefinitely.
    hsel = 1'b1; htrans = T_NSEQ; hwrite = 1'b0; hsize = 3'd2; haddr = 32'h30;
    @(posedge hclk); #1;
    hsel = 1'b0; htrans = T_IDLE;
`ifdef AHBSLV_WBMAS_TIMEOUT_EN
    n = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge hclk);
      if (hreadyout) break;
      n++;
    end
    chk("tmo_waits", 32'(n), 32'd5);
    chk("tmo_resp", 32'(hresp), 32'(R_ERR));
    chk("tmo_cyc", 32'(cyc_o), 32'd0);
    @(posedge hclk); #1;
`else
    repeat (20) @(posedge hclk);
    @(negedge hclk);
    chk("nohang_cyc", 32'(cyc_o), 32'd1);
    chk("nohang_ready", 32'(hreadyout), 32'd0);
    chk("nohang_state", 32'(dbg_state), 32'd1);
    @(posedge hclk); #1;
    ack_i = 1'b1; dat_i = 32'h600D_0030;
    @(posedge hclk); #1;
    ack_i = 1'b0;
    @(negedge hclk);
    chk("nohang_done", {hreadyout, hrdata[30:0]}, {1'b1, 31'h600D_0030});
    @(posedge hclk); #1;
`endif

    // Back-to-back reads, then reset during the second WB cycle with a late ack.
    hsel = 1'b1; htrans = T_NSEQ; hwrite = 1'b0; hsize = 3'd2; haddr = 32'h100;
    @(posedge hclk); #1;
    haddr = 32'h104; ack_i = 1'b1; dat_i = 32'hCAFE_0001;
    @(negedge hclk);
    chk("b2b_first_cyc", 32'({cyc_o, stb_o}), 32'd3);
    chk("b2b_first_adr", adr_o, 32'h100);
    @(posedge hclk); #1;
    ack_i = 1'b0;
    @(negedge hclk);
    chk("b2b_okay_cycle", 32'({hreadyout, hresp, cyc_o}), 32'({1'b1, R_OKAY, 1'b0}));
    chk("b2b_hrdata", hrdata, 32'hCAFE_0001);
    @(posedge hclk); #1;
    hsel = 1'b0; htrans = T_IDLE;
    @(negedge hclk);
    chk("b2b_second_cyc", 32'({cyc_o, hreadyout}), 32'({1'b1, 1'b0}));
    chk("b2b_second_adr", adr_o, 32'h104);
    #1 hresetn = 1'b0;
    #1;
    chk("rst_mid_cyc", 32'({cyc_o, stb_o}), 32'd0);
    chk("rst_mid_ready", 32'(hreadyout), 32'd1);
    chk("rst_mid_adr", adr_o, 32'd0);
    ack_i = 1'b1; dat_i = 32'h5555_5555;
    @(posedge hclk); #1;
    hresetn = 1'b1;
    @(negedge hclk);
    chk("late_ack_cyc", 32'(cyc_o), 32'd0);
    chk("late_ack_hrdata", hrdata, 32'd0);
    @(posedge hclk); #1;
    ack_i = 1'b0;
    @(negedge hclk);
    chk("late_ack_state", 32'({dbg_state, hreadyout}), 32'({2'd0, 1'b1}));

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1);
  end

endmodule

// File: doc/ahbslv_wbmas_bridge.md
AHBSLV_WBMAS_BRIDGE -- requirements
Module: ahbslv_wbmas_bridge

Interface
REQ-001 Parameter AWIDTH, default 32: address width of haddr and adr_o.
REQ-002 Parameter DWIDTH, default 32: data width; only 32 is supported.
REQ-003 Parameter TIMEOUT, default 255: WB wait-cycle limit; used only with REQ-028.
REQ-004 Port hclk, input, 1 bit: sole clock; all logic runs on its rising edge.
REQ-005 Port hresetn, input, 1 bit: reset; asynchronous, active-low.
REQ-006 Ports hsel, hwrite, hreadyin, input, 1 bit each: AHB slave select, transfer direction and bus-ready.
REQ-007 Ports haddr [AWIDTH], htrans [2], hsize [3], hburst [3], hwdata [DWIDTH], input: AHB address phase and write data.
REQ-008 Ports hreadyout (1 bit), hresp [2] and hrdata [DWIDTH], output: AHB slave response.
REQ-009 Ports adr_o [AWIDTH], dat_o [DWIDTH], sel_o [4], we_o, cyc_o and stb_o (1 bit each), output: Wishbone master request.
REQ-010 Ports dat_i [DWIDTH], ack_i and err_i (1 bit each), input: Wishbone slave response.

Function
REQ-011 The block SHALL accept a transfer when hsel=1, hreadyin=1 and htrans is NONSEQ(10) or SEQ(11) at a rising hclk edge; it SHALL register haddr, hwrite and hsize at that edge.
REQ-012 The FSM SHALL have states IDLE, WB_WAIT, ERR1 and ERR2.
REQ-013 IDLE: hreadyout=1, hresp=OKAY. An accepted legal transfer SHALL go to WB_WAIT. An accepted illegal transfer SHALL go to ERR1.
REQ-014 Illegal transfer: hsize>010, or the address is not aligned to hsize.
REQ-015 WB_WAIT: cyc_o=stb_o=1 and hreadyout=0. adr_o, we_o and sel_o SHALL come from the registered address phase.
REQ-016 In WB_WAIT, dat_o SHALL follow hwdata combinationally; the master holds hwdata stable while hreadyout=0.
REQ-017 ack_i=1 in WB_WAIT: cyc_o and stb_o SHALL drop at the next edge, hreadyout=1 with hresp=OKAY for one cycle, and hrdata SHALL register dat_i on reads.
REQ-018 err_i=1 in WB_WAIT (err_i takes priority over ack_i): cyc_o and stb_o SHALL drop, then ERR1 (hreadyout=0, hresp=ERROR), then ERR2 (hreadyout=1, hresp=ERROR), then IDLE.
REQ-019 A zero-wait WB slave SHALL give one AHB wait state; each extra WB wait cycle SHALL add one AHB wait state.
REQ-020 A new transfer accepted in the OKAY-response cycle SHALL go directly to WB_WAIT, so back-to-back pipelining has no bubble. A transfer accepted in ERR2 SHALL be handled the same way.
REQ-021 htrans IDLE(00) or BUSY(01) with hsel=1, or hsel=0, SHALL get a zero-wait OKAY with no WB cycle.
REQ-022 hburst SHALL be ignored; each beat is an independent single WB cycle.
REQ-023 sel_o SHALL be little-endian: byte gives a one-hot lane from addr[1:0]; halfword gives 0011 when addr[1]=0 and 1100 when addr[1]=1; word gives 1111.
REQ-024 Outside WB_WAIT, cyc_o, stb_o and we_o SHALL be 0; adr_o and sel_o SHALL hold their last values.

Reset
REQ-025 While hresetn=0, all outputs SHALL take reset values regardless of hclk: hreadyout=1, hresp=00, hrdata=0, adr_o=0, sel_o=0, we_o=cyc_o=stb_o=0, and the FSM SHALL be in IDLE.
REQ-026 Reset asserted mid-transfer SHALL drop cyc_o and stb_o immediately; a late ack_i or err_i after reset release SHALL be ignored in IDLE.
REQ-027 The first transfer SHALL be accepted at the first edge after hresetn deasserts.

Configuration
REQ-028 With macro AHBSLV_WBMAS_TIMEOUT_EN defined, a down-counter loaded with TIMEOUT on entry to WB_WAIT SHALL abort the WB cycle at zero and produce the two-cycle ERROR response of REQ-018.
REQ-029 Without AHBSLV_WBMAS_TIMEOUT_EN, the counter SHALL not exist and WB_WAIT SHALL wait indefinitely for ack_i or err_i.

Structure
REQ-030 The shared package ahb_wb_pkg SHALL hold the HTRANS and HRESP encodings, the HSIZE codes and the FSM state encoding; the existing Wishbone-slave/AHB-master bridge SHALL reuse it.
REQ-031 The byte-lane decode SHALL be one sub-module, ahb_wb_sel_dec (hsize and addr[1:0] in, sel out); the FSM stays in the top module.

Verification
REQ-032 Word write to 0x0000_1004 with data 0xDEADBEEF and ack_i on the first WB_WAIT cycle -> adr_o=0x1004, sel_o=1111, we_o=1, dat_o=0xDEADBEEF, one AHB wait state, hresp=OKAY.
REQ-033 Byte read at 0x0000_2003 with ack_i after 3 wait cycles and dat_i=0x12345678 -> sel_o=1000, 4 AHB wait states, hrdata=0x12345678.
REQ-034 err_i on a word read at 0x10 -> hreadyout/hresp sequence (0,ERROR) then (1,ERROR), then IDLE with an OKAY response.
REQ-035 Halfword write at 0x0000_0001 (unaligned) -> no cyc_o assertion, two-cycle ERROR response.
REQ-036 Two back-to-back NONSEQ word reads -> the second address phase is accepted in the OKAY cycle of the first with no idle cycle between WB cycles; hresetn pulsed low during the second WB_WAIT -> cyc_o=0 immediately and hreadyout=1.
REQ-037 With AHBSLV_WBMAS_TIMEOUT_EN defined, TIMEOUT=4 and ack_i held low -> abort after 4 WB_WAIT cycles with ERROR; without the macro -> the bridge stays in WB_WAIT.
